// File: rtl/scan_demux_pkg.sv
// Shared definitions for the scanning strobe demultiplexer: FSM encodings,
// a constant-safe clog2 and the strobe polarity level.
package scan_demux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ON    = 2'd1,
        ST_BLANK = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    // Value of the ACTIVE_LOW parameter that selects active-low strobes.
    localparam int POL_ACTIVE_LOW = 1;

    // Usable in localparam expressions; clog2_f(1) = 0.
    function automatic int clog2_f(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_demux_rr_next_index.sv
// Round-robin channel picker: lowest unmasked index searching upward from
// prev+1 modulo N_CH, with a wrap flag when the pick is not above prev.
module rr_next_index #(
    parameter int N_CH  = 4,
    parameter int SEL_W = 2
) (
    input  logic [SEL_W-1:0] i_prev,
    input  logic [N_CH-1:0]  i_mask,
    output logic [SEL_W-1:0] o_next,
    output logic             o_none_valid,
    output logic             o_wrap
);

    logic [SEL_W-1:0] w_cand [N_CH];

    // w_cand[gi] is the channel at search distance gi+1 from prev.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_cand
            assign w_cand[gi] = SEL_W'((int'(i_prev) + gi + 1) % N_CH);
        end
    endgenerate

    always_comb begin
        o_next       = '0;
        o_none_valid = 1'b1;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (!i_mask[w_cand[k]]) begin
                o_next       = w_cand[k];
                o_none_valid = 1'b0;
            end
        end
        o_wrap = !o_none_valid && (o_next <= i_prev);
    end

endmodule

// File: rtl/scan_demux.sv
// Time-multiplexed one-hot strobe generator with per-slot dwell, dead time,
// channel masking and a frame pulse on wrap. All outputs are registered.
module scan_demux
    import scan_demux_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int SEL_W      = 2,
    parameter int PRESCALE   = 50000,
    parameter int DEAD       = 16,
    parameter int ACTIVE_LOW = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ena,
    input  logic [N_CH-1:0]  i_mask,
    output logic [SEL_W-1:0] o_sel,
    output logic [N_CH-1:0]  o_strobe,
    output logic             o_frame
);

    localparam int CNT_MAX = (PRESCALE > DEAD) ? PRESCALE : DEAD;
    localparam int CNT_W   = clog2_f(CNT_MAX + 1);
    localparam logic [N_CH-1:0]  STROBE_IDLE = (ACTIVE_LOW == POL_ACTIVE_LOW) ? '1 : '0;
    localparam logic [SEL_W-1:0] PREV_INIT   = SEL_W'(N_CH - 1);
    localparam logic [N_CH-1:0]  ONE_HOT0    = N_CH'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_prev;
    logic [N_CH-1:0]  r_strobe;
    logic             r_frame;

    state_t           w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [SEL_W-1:0] w_sel_next;
    logic [SEL_W-1:0] w_prev_next;
    logic [N_CH-1:0]  w_strobe_act;
    logic             w_frame_next;

    logic [SEL_W-1:0] w_rr_next;
    logic             w_rr_none;
    logic             w_rr_wrap;
    logic             w_slot_end;
    logic             w_take;

    rr_next_index #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_rr (
        .i_prev       (r_prev),
        .i_mask       (i_mask),
        .o_next       (w_rr_next),
        .o_none_valid (w_rr_none),
        .o_wrap       (w_rr_wrap)
    );

    assign w_slot_end = (r_cnt == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_sel    <= '0;
            r_prev   <= PREV_INIT;
            r_strobe <= STROBE_IDLE;
            r_frame  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_sel    <= w_sel_next;
            r_prev   <= w_prev_next;
            r_strobe <= w_strobe_act ^ STROBE_IDLE;
            r_frame  <= w_frame_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!i_ena) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_next = w_rr_none ? ST_WAIT : ST_ON;
                ST_ON: begin
                    if (w_slot_end) begin
                        if (DEAD > 0)       w_state_next = ST_BLANK;
                        else if (w_rr_none) w_state_next = ST_WAIT;
                        else                w_state_next = ST_ON;
                    end
                end
                ST_BLANK: begin
                    if (w_slot_end) w_state_next = w_rr_none ? ST_WAIT : ST_ON;
                end
                ST_WAIT:  w_state_next = w_rr_none ? ST_WAIT : ST_ON;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    // A new channel is taken whenever ON is entered, or re-entered from the
    // last ON cycle when there is no dead time.
    assign w_take = (w_state_next == ST_ON) && ((r_state != ST_ON) || w_slot_end);

    always_comb begin
        w_cnt_next   = r_cnt;
        w_sel_next   = r_sel;
        w_prev_next  = r_prev;
        w_strobe_act = '0;
        w_frame_next = 1'b0;
        if (!i_ena) begin
            w_cnt_next  = '0;
            w_sel_next  = '0;
            w_prev_next = PREV_INIT;
        end else if (w_take) begin
            w_cnt_next   = CNT_W'(PRESCALE - 1);
            w_sel_next   = w_rr_next;
            w_prev_next  = w_rr_next;
            w_strobe_act = ONE_HOT0 << w_rr_next;
            w_frame_next = w_rr_wrap;
        end else if (w_state_next == ST_ON) begin
            w_cnt_next   = r_cnt - CNT_W'(1);
            w_strobe_act = ONE_HOT0 << r_sel;
        end else if (w_state_next == ST_BLANK) begin
            w_cnt_next = (r_state == ST_BLANK) ? r_cnt - CNT_W'(1) : CNT_W'(DEAD - 1);
        end else begin
            w_cnt_next = '0;
        end
    end

    assign o_sel    = r_sel;
    assign o_strobe = r_strobe;
    assign o_frame  = r_frame;

endmodule

// File: tb/tb_scan_demux.sv
// Directed bench: a vector table for the main configuration plus a
// hand-written sequence for the active-low, no-dead-time variant.
module tb_scan_demux;

    logic       clk = 1'b0;
    logic       rst, ena;
    logic [3:0] mask;
    logic [1:0] sel;
    logic [3:0] strobe;
    logic       frame;

    logic       v_rst, v_ena;
    logic [3:0] v_mask;
    logic [1:0] v_sel;
    logic [3:0] v_strobe;
    logic       v_frame;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    scan_demux #(.N_CH(4), .SEL_W(2), .PRESCALE(4), .DEAD(2), .ACTIVE_LOW(0)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_mask(mask),
        .o_sel(sel), .o_strobe(strobe), .o_frame(frame)
    );

    scan_demux #(.N_CH(4), .SEL_W(2), .PRESCALE(4), .DEAD(0), .ACTIVE_LOW(1)) u_var (
        .i_clk(clk), .i_rst(v_rst), .i_ena(v_ena), .i_mask(v_mask),
        .o_sel(v_sel), .o_strobe(v_strobe), .o_frame(v_frame)
    );

    typedef struct {
        logic       rst;
        logic       ena;
        logic [3:0] mask;
        logic [3:0] strobe;
        logic [1:0] sel;
        logic       frame;
    } vec_t;

    vec_t tbl[$];
    bit   done = 1'b0;

    task automatic add(input logic r, input logic e, input logic [3:0] m,
                       input logic [3:0] s, input logic [1:0] c, input logic f);
        vec_t v;
        v.rst = r; v.ena = e; v.mask = m; v.strobe = s; v.sel = c; v.frame = f;
        tbl.push_back(v);
    endtask

    task automatic add_on(input int ch, input logic [3:0] m, input logic f);
        logic [3:0] s;
        s = 4'b0001 << ch;
        add(1'b0, 1'b1, m, s, 2'(ch), f);
        repeat (3) add(1'b0, 1'b1, m, s, 2'(ch), 1'b0);
    endtask

    task automatic add_blank(input int ch, input logic [3:0] m);
        repeat (2) add(1'b0, 1'b1, m, 4'b0000, 2'(ch), 1'b0);
    endtask

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: strobe/sel/frame got %b required %b", name, act, exp);
        end else begin
            $display("%s: strobe/sel/frame %b ok", name, act);
        end
    endtask

    // Strobe must never be multi-hot, on either instance, in any cycle.
    always @(negedge clk) begin
        if (!done) begin
            n_cmp++;
            if ($countones(strobe) > 1 || $countones(~v_strobe) > 1) begin
                n_bad++;
                $display("FAIL onehot: strobe %b variant %b, at most one active bit required",
                         strobe, v_strobe);
            end
        end
    end

    initial begin
        rst = 1'b1; ena = 1'b1; mask = 4'b0000;
        v_rst = 1'b1; v_ena = 1'b0; v_mask = 4'b0000;

        // Reset held with enable high: nothing active.
        repeat (3) add(1'b1, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
        // Full scan, two frames, then the wrap pulse 24 cycles later.
        for (int rep = 0; rep < 2; rep++)
            for (int ch = 0; ch < 4; ch++) begin
                add_on(ch, 4'b0000, (ch == 0));
                add_blank(ch, 4'b0000);
            end
        add(1'b0, 1'b1, 4'b0000, 4'b0001, 2'd0, 1'b1);
        add(1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
        // Channels 0 and 2 skipped: 12-cycle frame.
        for (int rep = 0; rep < 2; rep++) begin
            add_on(1, 4'b0101, 1'b1);
            add_blank(1, 4'b0101);
            add_on(3, 4'b0101, 1'b0);
            add_blank(3, 4'b0101);
        end
        add(1'b0, 1'b1, 4'b0101, 4'b0010, 2'd1, 1'b1);
        add(1'b0, 1'b0, 4'b0101, 4'b0000, 2'd0, 1'b0);
        // Mask everything during ch1: slot and blank complete, then WAIT.
        add_on(0, 4'b0000, 1'b1);
        add_blank(0, 4'b0000);
        add(1'b0, 1'b1, 4'b0000, 4'b0010, 2'd1, 1'b0);
        repeat (3) add(1'b0, 1'b1, 4'b1111, 4'b0010, 2'd1, 1'b0);
        repeat (2) add(1'b0, 1'b1, 4'b1111, 4'b0000, 2'd1, 1'b0);
        repeat (3) add(1'b0, 1'b1, 4'b1111, 4'b0000, 2'd1, 1'b0);
        add(1'b0, 1'b1, 4'b1110, 4'b0001, 2'd0, 1'b1);
        add(1'b0, 1'b0, 4'b1110, 4'b0000, 2'd0, 1'b0);
        // All masked straight from IDLE, then only channel 2 released.
        repeat (2) add(1'b0, 1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0);
        add(1'b0, 1'b1, 4'b1011, 4'b0100, 2'd2, 1'b1);
        add(1'b0, 1'b0, 4'b1011, 4'b0000, 2'd0, 1'b0);
        // Abort by enable on ch2's second ON cycle, then re-enable.
        add_on(0, 4'b0000, 1'b1);
        add_blank(0, 4'b0000);
        add_on(1, 4'b0000, 1'b0);
        add_blank(1, 4'b0000);
        repeat (2) add(1'b0, 1'b1, 4'b0000, 4'b0100, 2'd2, 1'b0);
        add(1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0);
        add(1'b0, 1'b1, 4'b0000, 4'b0001, 2'd0, 1'b1);
        repeat (3) add(1'b0, 1'b1, 4'b0000, 4'b0001, 2'd0, 1'b0);
        add_blank(0, 4'b0000);
        add_on(1, 4'b0000, 1'b0);
        add_blank(1, 4'b0000);
        // Same abort using reset instead of enable.
        repeat (2) add(1'b0, 1'b1, 4'b0000, 4'b0100, 2'd2, 1'b0);
        add(1'b1, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
        add(1'b0, 1'b1, 4'b0000, 4'b0001, 2'd0, 1'b1);
        add(1'b0, 1'b1, 4'b0000, 4'b0001, 2'd0, 1'b0);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst; ena = tbl[i].ena; mask = tbl[i].mask;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), {strobe, sel, frame},
                {tbl[i].strobe, tbl[i].sel, tbl[i].frame});
        end

        // Active-low, no dead time: back-to-back slots, 16-cycle frame.
        @(negedge clk);
        v_rst = 1'b1; v_ena = 1'b1;
        @(posedge clk);
        #1;
        chk("var_reset", {v_strobe, v_sel, v_frame}, {4'b1111, 2'd0, 1'b0});
        for (int ch = 0; ch < 5; ch++) begin
            for (int j = 0; j < 4; j++) begin
                logic [3:0] s;
                if (ch == 4 && j > 0) break;
                s = ~(4'b0001 << (ch % 4));
                @(negedge clk);
                v_rst = 1'b0;
                @(posedge clk);
                #1;
                chk($sformatf("var_ch%0d_c%0d", ch, j), {v_strobe, v_sel, v_frame},
                    {s, 2'(ch % 4), (ch % 4 == 0) && (j == 0)});
            end
        end

        @(negedge clk);
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
